// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: a fixed acquisition window, then an
// MSB-first binary search driven through an external DAC and comparator.
module sar_adc_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SAMPLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_in,
  output logic             sample,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out
);

  localparam int CNT_W = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] bit_mask;  // one-hot marker of the bit currently on trial
  logic [WIDTH-1:0] resolved;

  // NOTE: every variable written here gets a default on the first line, so no latch is inferred.
  always_comb begin
    resolved = dac_code & ~bit_mask;
    if (cmp_in) resolved = resolved | bit_mask;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_mask <= '0;
      sample   <= 1'b0;
      dac_code <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= SAMPLE;
            sample <= 1'b1;
            busy   <= 1'b1;
            cnt    <= CNT_W'(SAMPLE_CYCLES - 1);
          end
        end
        SAMPLE: begin
          if (cnt == '0) begin
            state    <= CONVERT;
            sample   <= 1'b0;
            bit_mask <= MSB;
            dac_code <= MSB;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        CONVERT: begin
          // dac_code already holds r | (1<<k); the comparator decides bit k.
          if (bit_mask[0]) begin
            state    <= DONE;
            done     <= 1'b1;
            data_out <= resolved;
            dac_code <= '0;
            bit_mask <= '0;
          end else begin
            bit_mask <= bit_mask >> 1;
            dac_code <= resolved | (bit_mask >> 1);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Bench for sar_adc_ctrl: directed vector table, hand-written corner sequences and
// randomized traffic checked cycle by cycle against a binary-search trace model.
module tb_sar_adc_ctrl;

  localparam int W  = 8;
  localparam int SC = 2;

  logic         clk = 1'b0;
  logic         rst, start, cmp_in, conv_now;
  logic         sample, busy, done;
  logic [W-1:0] dac_code, data_out, vin;

  logic         start2, cmp2, sample2, busy2, done2;
  logic [3:0]   dac2, data_out2, vin2;

  always #5 clk = ~clk;

  // Ideal comparator; outside conversion it is driven unknown to prove it is ignored.
  assign cmp_in = conv_now ? (vin >= dac_code) : 1'bx;
  assign cmp2   = (vin2 >= dac2);

  sar_adc_ctrl #(.WIDTH(W), .SAMPLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .start(start), .cmp_in(cmp_in), .sample(sample),
    .dac_code(dac_code), .busy(busy), .done(done), .data_out(data_out)
  );

  sar_adc_ctrl #(.WIDTH(4), .SAMPLE_CYCLES(1)) dut_small (
    .clk(clk), .rst(rst), .start(start2), .cmp_in(cmp2), .sample(sample2),
    .dac_code(dac2), .busy(busy2), .done(done2), .data_out(data_out2)
  );

  typedef struct packed {
    logic         sample;
    logic         busy;
    logic         done;
    logic         conv;
    logic         chk_dac;
    logic [W-1:0] dac;
    logic [W-1:0] res;
  } exp_t;

  typedef struct {
    logic [W-1:0] vin;
    logic [W-1:0] res;
    logic [W-1:0] last_trial;
  } vec_t;

  exp_t         exp_q[$];
  logic [W-1:0] exp_data;
  int           n_vec = 0, n_bad = 0;
  int           cyc = 0, done_cnt = 0, done_at = 0, idle_cnt = 0;
  int           done_log[$];
  logic [W-1:0] s_dac, s_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, req);
    end
  endtask

  // Expected trace of one conversion: plain binary search over the code range.
  task automatic push_conversion();
    exp_t         e;
    logic [W-1:0] r, trial;
    r = '0;
    for (int i = 0; i < SC; i++) begin
      e = '0; e.sample = 1'b1; e.busy = 1'b1; e.chk_dac = 1'b1;
      exp_q.push_back(e);
    end
    for (int b = W - 1; b >= 0; b--) begin
      trial = r + W'(1 << b);
      e = '0; e.busy = 1'b1; e.conv = 1'b1; e.chk_dac = 1'b1; e.dac = trial;
      exp_q.push_back(e);
      if (vin >= trial) r = trial;
    end
    e = '0; e.busy = 1'b1; e.done = 1'b1; e.res = r;
    exp_q.push_back(e);
  endtask

  // Check the current cycle mid-period, then drive inputs for the next edge.
  task automatic tick(input logic st, input logic rs);
    exp_t e;
    logic was_idle;
    @(negedge clk);
    was_idle = (exp_q.size() == 0);
    if (was_idle) begin
      e = '0; e.chk_dac = 1'b1;
    end else begin
      e = exp_q.pop_front();
    end
    if (e.done) exp_data = e.res;
    conv_now = e.conv;
    check("sample", 32'(sample), 32'(e.sample));
    check("busy", 32'(busy), 32'(e.busy));
    check("done", 32'(done), 32'(e.done));
    check("data_out", 32'(data_out), 32'(exp_data));
    if (e.chk_dac) check("dac_code", 32'(dac_code), 32'(e.dac));
    s_dac  = dac_code;
    s_data = data_out;
    if (done) begin
      done_cnt++;
      done_at = cyc;
      done_log.push_back(cyc);
    end
    if (!busy) idle_cnt++;
    start = st;
    rst   = rs;
    if (rs) begin
      exp_q.delete();
      exp_data = '0;
    end else if (was_idle && st) begin
      push_conversion();
    end
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t         tbl[4];
    logic [W-1:0] t1_codes[8];
    logic [3:0]   t6_codes[4];
    logic [W-1:0] last;
    int           t0;

    tbl[0] = '{vin: 8'hB4, res: 8'hB4, last_trial: 8'hB5};
    tbl[1] = '{vin: 8'h00, res: 8'h00, last_trial: 8'h01};
    tbl[2] = '{vin: 8'hFF, res: 8'hFF, last_trial: 8'hFF};
    tbl[3] = '{vin: 8'h5A, res: 8'h5A, last_trial: 8'h5B};
    t1_codes = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hB8, 8'hB4, 8'hB6, 8'hB5};
    t6_codes = '{4'h8, 4'hC, 4'hA, 4'h9};

    rst = 1'b1; start = 1'b0; conv_now = 1'b0; vin = '0;
    start2 = 1'b0; vin2 = '0;
    exp_data = '0;
    repeat (2) @(posedge clk);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);

    // Directed single conversions, including both ends of the code range.
    for (int i = 0; i < 4; i++) begin
      vin = tbl[i].vin;
      done_cnt = 0;
      last = '0;
      t0 = cyc;
      tick(1'b1, 1'b0);
      for (int k = 1; k <= 12; k++) begin
        tick(1'b0, 1'b0);
        if (i == 0 && k >= 3 && k <= 10) check("t1_trial_code", 32'(s_dac), 32'(t1_codes[k-3]));
        if (k == 10) last = s_dac;
      end
      check("vec_done_count", done_cnt, 1);
      check("vec_done_cycle", done_at - t0, 11);
      check("vec_result", 32'(s_data), 32'(tbl[i].res));
      check("vec_last_trial", 32'(last), 32'(tbl[i].last_trial));
    end

    // Reset in cycle 6 aborts the conversion and clears data_out.
    vin = 8'h77;
    done_cnt = 0;
    tick(1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    check("rst_no_done", done_cnt, 0);
    check("rst_data_cleared", 32'(s_data), 0);
    vin = 8'h3C;
    tick(1'b1, 1'b0);
    for (int k = 1; k <= 12; k++) tick(1'b0, 1'b0);
    check("after_rst_result", 32'(s_data), 32'h3C);

    // start held high: one done every 12 cycles, never restarted mid-conversion.
    vin = 8'h5A;
    done_log.delete();
    t0 = cyc;
    repeat (60) tick(1'b1, 1'b0);
    check("held_done_count", done_log.size(), 5);
    for (int i = 0; i < done_log.size(); i++) check("held_done_cycle", done_log[i] - t0, 11 + 12 * i);
    repeat (14) tick(1'b0, 1'b0);

    // Back-to-back: 0x33 held until the second done, busy low for one cycle between.
    vin = 8'h33;
    t0 = cyc;
    tick(1'b1, 1'b0);
    idle_cnt = 0;
    for (int k = 1; k <= 11; k++) tick(1'b0, 1'b0);
    vin = 8'hCC;
    tick(1'b1, 1'b0);
    for (int k = 13; k <= 23; k++) begin
      tick(1'b0, 1'b0);
      if (k == 22) check("b2b_hold_first", 32'(s_data), 32'h33);
    end
    check("b2b_second_result", 32'(s_data), 32'hCC);
    check("b2b_idle_cycles", idle_cnt, 1);
    check("b2b_second_done", done_at - t0, 23);
    repeat (3) tick(1'b0, 1'b0);

    // Randomized traffic: random codes, random start requests, rare resets.
    for (int n = 0; n < 600; n++) begin
      if (exp_q.size() == 0) vin = W'($urandom);
      tick(($urandom_range(0, 2) == 0), ($urandom_range(0, 150) == 0));
    end
    repeat (16) tick(1'b0, 1'b0);

    // Narrow instance: WIDTH=4, SAMPLE_CYCLES=1.
    @(negedge clk);
    vin2 = 4'h9;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    check("t6_sample", 32'(sample2), 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t6_sample_low", 32'(sample2), 0);
      check("t6_trial_code", 32'(dac2), 32'(t6_codes[k]));
    end
    @(negedge clk);
    check("t6_done", 32'(done2), 1);
    check("t6_result", 32'(data_out2), 32'h9);
    @(negedge clk);
    check("t6_idle", 32'(busy2), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
